// File: rtl/wb_select_stage_if.sv
// Writeback stage bus bundle: MEM-stage instruction, memory response and
// register-file write port.
//   master : drives instruction/memory inputs and flush, observes results
//   slave  : the writeback stage itself
interface wb_select_stage_if #(
    parameter int unsigned XLEN = 32
);
    localparam int unsigned OFFW = $clog2(XLEN / 8);

    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_sel;
    logic            in_reg_write;
    logic [4:0]      in_rd;
    logic [XLEN-1:0] in_alu_result;
    logic [XLEN-1:0] in_csr_rdata;
    logic [XLEN-1:0] in_pc;
    logic            in_compressed;
    logic [2:0]      in_funct3;
    logic [OFFW-1:0] in_addr_lo;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            flush;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            load_err;
    logic            busy;

    modport master (
        output in_valid, in_sel, in_reg_write, in_rd, in_alu_result,
               in_csr_rdata, in_pc, in_compressed, in_funct3, in_addr_lo,
               mem_rvalid, mem_rdata, flush,
        input  in_ready, rf_we, rf_waddr, rf_wdata, load_err, busy
    );

    modport slave (
        input  in_valid, in_sel, in_reg_write, in_rd, in_alu_result,
               in_csr_rdata, in_pc, in_compressed, in_funct3, in_addr_lo,
               mem_rvalid, mem_rdata, flush,
        output in_ready, rf_we, rf_waddr, rf_wdata, load_err, busy
    );
endinterface

// File: rtl/wb_select_stage.sv
// Registered writeback stage: selects ALU / load / CSR / link data for the
// register file, waits for late load data, aligns and extends sub-word loads,
// honours flush and flags a load that never returns.
//   clk, rst : core clock, synchronous active-high reset
//   bus      : wb_select_stage_if slave (instruction in, memory response in,
//              register-file write out, in_ready/busy status)
module wb_select_stage #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned OFFW    = $clog2(XLEN / 8)
) (
    input logic               clk,
    input logic               rst,
    wb_select_stage_if.slave  bus
);
    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [1:0]  SEL_ALU = 2'd0;
    localparam logic [1:0]  SEL_MEM = 2'd1;
    localparam logic [1:0]  SEL_CSR = 2'd2;

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [4:0]      rd_q, rd_d;
    logic            rw_q, rw_d;
    logic [2:0]      f3_q, f3_d;
    logic [OFFW-1:0] off_q, off_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic            load_err_q, load_err_d;
    logic            accept_c;

    // Shift the addressed lane down to bit 0, then extend per funct3.
    function automatic logic [XLEN-1:0] load_extract(
        input logic [XLEN-1:0] rdata,
        input logic [2:0]      f3,
        input logic [OFFW-1:0] off
    );
        logic [OFFW-1:0] h_off;
        logic [OFFW-1:0] w_off;
        logic [XLEN-1:0] b_sh;
        logic [XLEN-1:0] h_sh;
        logic [XLEN-1:0] w_sh;
        logic [XLEN-1:0] res;
        h_off = off & ~OFFW'(1);
        w_off = off & ~OFFW'(3);
        b_sh  = rdata >> {off, 3'b000};
        h_sh  = rdata >> {h_off, 3'b000};
        w_sh  = rdata >> {w_off, 3'b000};
        case (f3)
            3'b000:  res = XLEN'($signed(b_sh[7:0]));
            3'b100:  res = XLEN'(b_sh[7:0]);
            3'b001:  res = XLEN'($signed(h_sh[15:0]));
            3'b101:  res = XLEN'(h_sh[15:0]);
            3'b010:  res = XLEN'($signed(w_sh[31:0]));
            3'b110:  res = (XLEN == 64) ? XLEN'(w_sh[31:0]) : rdata;
            default: res = rdata;
        endcase
        return res;
    endfunction

    assign bus.in_ready = (state_q == IDLE) && !rst;
    assign bus.busy     = (state_q == WAIT_MEM) && !rst;
    assign accept_c     = bus.in_valid && bus.in_ready && !bus.flush;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_q       <= '0;
            rw_q       <= 1'b0;
            f3_q       <= '0;
            off_q      <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            rw_q       <= rw_d;
            f3_q       <= f3_d;
            off_q      <= off_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            load_err_q <= load_err_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        rw_d       = rw_q;
        f3_d       = f3_q;
        off_d      = off_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        load_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (bus.in_sel != SEL_MEM) begin
                        rf_we_d    = bus.in_reg_write && (bus.in_rd != 5'd0);
                        rf_waddr_d = bus.in_rd;
                        case (bus.in_sel)
                            SEL_ALU: rf_wdata_d = bus.in_alu_result;
                            SEL_CSR: rf_wdata_d = bus.in_csr_rdata;
                            default: rf_wdata_d = bus.in_pc +
                                         (bus.in_compressed ? XLEN'(2) : XLEN'(4));
                        endcase
                    end else if (bus.mem_rvalid) begin
                        rf_we_d    = bus.in_reg_write && (bus.in_rd != 5'd0);
                        rf_waddr_d = bus.in_rd;
                        rf_wdata_d = load_extract(bus.mem_rdata, bus.in_funct3,
                                                  bus.in_addr_lo);
                    end else begin
                        rd_d    = bus.in_rd;
                        rw_d    = bus.in_reg_write;
                        f3_d    = bus.in_funct3;
                        off_d   = bus.in_addr_lo;
                        cnt_d   = '0;
                        state_d = WAIT_MEM;
                    end
                end
            end
            WAIT_MEM: begin
                cnt_d = cnt_q + CW'(1);
                // flush beats a same-cycle response; a response beats timeout
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (bus.mem_rvalid) begin
                    rf_we_d    = rw_q && (rd_q != 5'd0);
                    rf_waddr_d = rd_q;
                    rf_wdata_d = load_extract(bus.mem_rdata, f3_q, off_q);
                    state_d    = IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    load_err_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rf_we    = rf_we_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.load_err = load_err_q;
endmodule

// File: doc/wb_select_stage.md
# wb_select_stage

Registered, parametrised writeback stage for the RV core. It sits between the memory stage and the register file. Per instruction it selects ALU result, load data, CSR old value or link address. Unlike a purely combinational writeback mux, it waits a variable number of cycles for load data, aligns and sign-extends sub-word loads, supports compressed-instruction link addresses and flushes, and times out on a missing memory response.

## Interface
- XLEN, 32 — datapath width; legal values 32 or 64
- TIMEOUT, 16 — maximum cycles to wait for mem_rvalid (≥2)
- OFFW, $clog2(XLEN/8) — byte-offset width (derived; do not override)

- clk  in  1  core clock
- rst  in  1  reset; one clock, synchronous, active-high
- in_valid  in  1  MEM stage presents an instruction
- in_ready  out  1  stage can accept; combinational, = (state==IDLE) && !rst
- in_sel  in  2  source select: 0 ALU, 1 MEM, 2 CSR, 3 LINK
- in_reg_write  in  1  instruction writes rd
- in_rd  in  5  destination register
- in_alu_result  in  XLEN  ALU result
- in_csr_rdata  in  XLEN  CSR old value
- in_pc  in  XLEN  instruction PC
- in_compressed  in  1  16-bit instruction; link = pc+2, else pc+4
- in_funct3  in  3  load type
- in_addr_lo  in  OFFW  load byte offset
- mem_rvalid  in  1  load data valid
- mem_rdata  in  XLEN  raw aligned-word load data
- flush  in  1  discard in-flight and same-cycle instruction
- rf_we  out  1  register file write enable (registered)
- rf_waddr  out  5  write address (registered)
- rf_wdata  out  XLEN  write data (registered)
- load_err  out  1  one-cycle pulse on load timeout
- busy  out  1  = (state==WAIT_MEM)

## Operation
- States: IDLE, WAIT_MEM.
- Accept occurs when in_valid && in_ready && !flush.
- IDLE, accept, in_sel≠1 → next cycle rf_we=in_reg_write&&(in_rd≠0), rf_waddr=in_rd. rf_wdata is ALU / CSR / link per in_sel. State stays IDLE.
- IDLE, accept, in_sel==1, mem_rvalid high the same cycle → write next cycle with extracted load data. State stays IDLE.
- IDLE, accept, in_sel==1, mem_rvalid low → capture rd, reg_write, funct3 and addr_lo, then go to WAIT_MEM. Clear the counter.
- WAIT_MEM behaviour:
  - The counter increments each cycle.
  - mem_rvalid → write next cycle and return to IDLE.
  - If the counter reaches TIMEOUT-1 without mem_rvalid → load_err=1 next cycle, no write, return to IDLE.
  - mem_rvalid on the timeout cycle wins: write, no error.
- mem_rvalid is ignored in IDLE unless accompanying a MEM accept.
- flush has priority over everything except rst:
  - In IDLE: the same-cycle input is not accepted and rf_we=0 next cycle.
  - In WAIT_MEM: return to IDLE with no write and no load_err, even if mem_rvalid is high.
- Load extract: byte lane = addr_lo; the halfword uses addr_lo with bit 0 ignored; the word (XLEN=64) uses addr_lo[2].
  - 000 LB sign-extends; 100 LBU zero-extends.
  - 001 LH sign-extends; 101 LHU zero-extends.
  - 010 LW sign-extends to XLEN; 110 LWU zero-extends (XLEN=64 only).
  - 011 LD (XLEN=64) passes through.
  - All other funct3 values pass mem_rdata through unchanged.
- Link arithmetic is modulo 2^XLEN: pc=all-ones, non-compressed → 3.
- rf_we is 0 on every cycle without a completed write.

## Timing
- Reset (rst high at clk edge): state=IDLE, rf_we=0, rf_waddr=0, rf_wdata=0, load_err=0, counter=0. busy=0 and in_ready=0 during rst.
- Reset mid-WAIT_MEM aborts silently: no write, no error.
- Latency: accept→rf_we is 1 cycle for non-MEM instructions. For loads, mem_rvalid→rf_we is 1 cycle.
- Throughput: 1 instruction/cycle for non-MEM instructions and for hit-same-cycle loads. in_ready stays low for the whole WAIT_MEM period.
- Timeout: accept at cycle 0 with no rvalid → load_err high in cycle TIMEOUT+1.
- All outputs except in_ready and busy are registered.

## Test plan
- ALU back-to-back: sel=0, rd=5 then rd=6, results 0x11 and 0x22 on consecutive cycles → rf_we=1 for two cycles, rf_waddr/rf_wdata 5/0x11 then 6/0x22; rd=0 gives rf_we=0.
- LINK: pc=0x1000, compressed=0 → 0x1004; compressed=1 → 0x1002; pc=0xFFFFFFFE, compressed=0 → 0x00000002.
- Delayed load: sel=1, LB, addr_lo=3, rvalid 3 cycles later with rdata=0x80FF_0000 → in_ready low for 3 cycles, then rf_wdata=0xFFFFFF80. Same with LHU, addr_lo=2 → 0x000080FF.
- Timeout with TIMEOUT=4: load accepted, no rvalid → load_err pulse in cycle 5, no rf_we, in_ready high afterwards.
- Flush: flush in WAIT_MEM together with rvalid → no write, no load_err. Flush with in_valid in IDLE → no write next cycle.
- Reset mid-wait followed by a CSR instruction (csr_rdata=0xDEAD) → outputs return to zero. After reset releases, the CSR instruction is accepted and rf_wdata=0xDEAD one cycle later.
